// File: rtl/memory_pkg.sv
// Shared constants and word/address types for the single-port storage block.
// Default geometry is 256 x 32; instances may override through parameters.
package memory_pkg;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    typedef logic [AW-1:0]    addr_t;
    typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/mem_occupancy.sv
// Occupancy counter: counts locations written at least once since reset.
// One-cycle update; full is combinational from the count register.
module mem_occupancy #(
    parameter  int depth = 256,
    localparam int AW    = $clog2(depth)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en_i,
    input  logic        was_valid_i,
    output logic [AW:0] count_o,
    output logic        full_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

    logic [AW:0] count_q, count_d;

    // Only first-time writes allocate; the saturation guard keeps count <= depth.
    always_comb begin
        count_d = count_q;
        if (write_en_i && !was_valid_i && (count_q != FULL_CNT)) begin
            count_d = count_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == FULL_CNT);

endmodule

// File: rtl/memory.sv
// Single-port RAM, write-first, registered read; unwritten words read as zero.
// Read latency 1 cycle; no backpressure, one access per cycle.
module memory
    import memory_pkg::*;
#(
    parameter  int width = WIDTH,
    parameter  int depth = DEPTH,
    localparam int AW    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    address,
    input  logic [width-1:0] datain,
    input  logic             write_en,
    output logic [width-1:0] data_out,
    output logic             full
);

    logic [width-1:0] mem_q [depth];
    logic [depth-1:0] valid_q, valid_d;
    logic [width-1:0] data_out_q, data_out_d;
    logic             was_valid;
    logic [AW:0]      count;

    assign was_valid = valid_q[address];

    // Write-first: a same-cycle write is forwarded straight to the read register.
    always_comb begin
        valid_d    = valid_q;
        data_out_d = '0;
        if (write_en) begin
            valid_d[address] = 1'b1;
            data_out_d       = datain;
        end else if (was_valid) begin
            data_out_d = mem_q[address];
        end
    end

    // Array is never cleared; stale contents are hidden by the valid bits.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[address] <= datain;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            data_out_q <= '0;
        end else begin
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
        end
    end

    mem_occupancy #(
        .depth (depth)
    ) u_occ (
        .clk         (clk),
        .rst         (rst),
        .write_en_i  (write_en),
        .was_valid_i (was_valid),
        .count_o     (count),
        .full_o      (full)
    );

    assign data_out = data_out_q;

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: stimulus pushes expected {data_out, full} after
// each capture edge; a negedge monitor pops and compares.
module tb_memory;

    localparam int W = 32;
    localparam int D = 256;
    localparam int A = 8;

    logic         clk;
    logic         rst;
    logic [A-1:0] address;
    logic [W-1:0] datain;
    logic         write_en;
    logic [W-1:0] data_out;
    logic         full;

    memory #(.width(W), .depth(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .datain   (datain),
        .write_en (write_en),
        .data_out (data_out),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] dat;
        logic         full;
        logic [A-1:0] addr;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: plain arrays of contents and "ever written" flags.
    logic [W-1:0] mdl_mem [D];
    bit           mdl_wr  [D];
    int           mdl_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) mdl_wr[i] = 1'b0;
        mdl_cnt = 0;
    endtask

    // Drive one access, advance through its capture edge, then publish the expectation.
    task automatic access(input logic we, input logic [A-1:0] a, input logic [W-1:0] d);
        exp_t e;
        write_en = we;
        address  = a;
        datain   = d;
        if (we) begin
            e.dat = d;
            if (!mdl_wr[a]) mdl_cnt++;
            mdl_wr[a]  = 1'b1;
            mdl_mem[a] = d;
        end else begin
            e.dat = mdl_wr[a] ? mdl_mem[a] : '0;
        end
        e.full = (mdl_cnt == D);
        e.addr = a;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("data_out@%02h", e.addr), 64'(data_out), 64'(e.dat));
            check($sformatf("full@%02h", e.addr), 64'(full), 64'(e.full));
        end
    end

    task automatic drain();
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        write_en = 1'b0;
        address  = '0;
        datain   = '0;
        model_reset();
        #2;
        check("init_data_out", 64'(data_out), 64'd0);
        check("init_full", 64'(full), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset state visible through reads
        access(1'b0, 8'h00, '0);
        access(1'b0, 8'h7F, '0);
        access(1'b0, 8'hFF, '0);

        // Basic write/read and neighbour
        access(1'b1, 8'h05, 32'hDEADBEEF);
        access(1'b0, 8'h05, '0);
        access(1'b0, 8'h06, '0);

        // Write-first collision
        access(1'b1, 8'h10, 32'h12345678);
        access(1'b0, 8'h10, '0);

        // Randomized mix over a small address window to force hits and overwrites
        for (int i = 0; i < 300; i++) begin
            access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), W'($urandom));
        end
        drain();

        // Fill from a clean state; full must flip exactly after address 0xFF
        do_reset();
        for (int i = 0; i < D; i++) begin
            access(1'b1, 8'(i), W'($urandom));
        end
        access(1'b1, 8'h00, 32'hA5A5A5A5);
        access(1'b0, 8'h00, '0);
        access(1'b0, 8'h80, '0);
        drain();
        check("full_before_async_rst", 64'(full), 64'd1);

        // Asynchronous reset between edges, then stale data must be masked
        do_reset();
        access(1'b0, 8'h05, '0);
        access(1'b0, 8'hFF, '0);
        drain();

        // Repeated overwrite of one location occupies one slot only
        for (int i = 0; i < D; i++) begin
            access(1'b1, 8'h20, W'($urandom));
        end
        access(1'b0, 8'h20, '0);
        drain();
        check("full_after_overwrites", 64'(full), 64'd0);
        check("count_after_overwrites", 64'(dut.u_occ.count_o), 64'(mdl_cnt));
        check("count_is_one", 64'(dut.u_occ.count_o), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
